// File: rtl/srl_shift_responder_if.sv
// Handshake/bus bundle for srl_shift_responder.
// master: drives shift/tap/injection controls; slave: the shift register itself.
interface srl_shift_responder_if #(
    parameter int SRL_LENGTH = 32
);
    localparam int AW = $clog2(SRL_LENGTH);

    logic          srl_sh;
    logic [AW-1:0] srl_a;
    logic          srl_d;
    logic          srl_q;
    logic          q_casc;
    logic          inj_req;
    logic          inj_ack;
    logic          tap_valid;
    logic [15:0]   shift_cnt;

    modport master (
        output srl_sh, srl_a, srl_d, inj_req,
        input  srl_q, q_casc, inj_ack, tap_valid, shift_cnt
    );

    modport slave (
        input  srl_sh, srl_a, srl_d, inj_req,
        output srl_q, q_casc, inj_ack, tap_valid, shift_cnt
    );
endinterface

// File: rtl/srl_shift_responder.sv
// Addressable shift register (SRL-style) with single-bit error injection,
// fill tracking for tap validity and a saturating shift counter.
// Optional macro SRL_SHIFT_RESPONDER_QREG_EN registers the tap output
// (srl_q gets one cycle of latency); q_casc and tap_valid are unaffected.
module srl_shift_responder #(
    parameter int                    SRL_LENGTH = 32,
    parameter logic [SRL_LENGTH-1:0] INIT       = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    srl_shift_responder_if.slave  bus
);
    localparam int                AW       = $clog2(SRL_LENGTH);
    localparam int                FW       = AW + 1;
    localparam logic [FW-1:0]     FILL_MAX = FW'(SRL_LENGTH);

    logic [SRL_LENGTH-1:0] mem_q, mem_d;
    logic                  inj_pending_q, inj_pending_d;
    logic                  inj_ack_q, inj_ack_d;
    logic [FW-1:0]         fill_cnt_q, fill_cnt_d;
    logic [15:0]           shift_cnt_q, shift_cnt_d;
    logic                  inject;
    logic                  in_bit;

    // Next-state: shift with injected bit, injection bookkeeping, counters.
    always_comb begin
        inject        = inj_pending_q | bus.inj_req;
        in_bit        = bus.srl_d ^ inject;
        mem_d         = mem_q;
        inj_pending_d = inj_pending_q;
        inj_ack_d     = 1'b0;
        fill_cnt_d    = fill_cnt_q;
        shift_cnt_d   = shift_cnt_q;
        if (bus.srl_sh) begin
            mem_d = {mem_q[SRL_LENGTH-2:0], in_bit};
            if (inject) begin
                inj_pending_d = 1'b0;
                inj_ack_d     = 1'b1;
            end
            if (fill_cnt_q != FILL_MAX) fill_cnt_d = fill_cnt_q + 1'b1;
            if (shift_cnt_q != 16'hFFFF) shift_cnt_d = shift_cnt_q + 16'd1;
        end else if (bus.inj_req) begin
            inj_pending_d = 1'b1;
        end
    end

    // State registers; reset wins over shift and injection on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q         <= INIT;
            inj_pending_q <= 1'b0;
            inj_ack_q     <= 1'b0;
            fill_cnt_q    <= '0;
            shift_cnt_q   <= '0;
        end else begin
            mem_q         <= mem_d;
            inj_pending_q <= inj_pending_d;
            inj_ack_q     <= inj_ack_d;
            fill_cnt_q    <= fill_cnt_d;
            shift_cnt_q   <= shift_cnt_d;
        end
    end

    assign bus.q_casc    = mem_q[SRL_LENGTH-1];
    assign bus.inj_ack   = inj_ack_q;
    assign bus.tap_valid = (fill_cnt_q > {1'b0, bus.srl_a});
    assign bus.shift_cnt = shift_cnt_q;

`ifdef SRL_SHIFT_RESPONDER_QREG_EN
    logic srl_q_q, srl_q_d;

    // Registered tap looks at post-edge contents so shifts and address
    // changes both appear exactly one cycle later.
    always_comb begin
        srl_q_d = mem_d[bus.srl_a];
    end

    // Tap output register, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) srl_q_q <= 1'b0;
        else     srl_q_q <= srl_q_d;
    end

    assign bus.srl_q = srl_q_q;
`else
    assign bus.srl_q = mem_q[bus.srl_a];
`endif
endmodule

// File: tb/tb_srl_shift_responder.sv
// Self-checking bench: two DUTs (INIT=0 and INIT=32'h8000_0001) share one
// stimulus stream; a history-based model predicts every output each cycle.
module tb_srl_shift_responder;
    localparam int L = 32;
    localparam logic [L-1:0] INIT0 = 32'h0000_0000;
    localparam logic [L-1:0] INIT1 = 32'h8000_0001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sh = 1'b0, d_i = 1'b0, req = 1'b0;
    logic [4:0] a_i = '0;

    int errors = 0;
    int checks = 0;

    // Model: newest shifted-in bit at hist[0]
    bit hist[$];
    int nshift = 0;
    bit pend = 1'b0, ack_e = 1'b0, qreg0 = 1'b0, qreg1 = 1'b0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    srl_shift_responder_if #(.SRL_LENGTH(L)) bus0 ();
    srl_shift_responder_if #(.SRL_LENGTH(L)) bus1 ();

    assign bus0.srl_sh = sh;  assign bus1.srl_sh = sh;
    assign bus0.srl_d  = d_i; assign bus1.srl_d  = d_i;
    assign bus0.srl_a  = a_i; assign bus1.srl_a  = a_i;
    assign bus0.inj_req = req; assign bus1.inj_req = req;

    srl_shift_responder #(.SRL_LENGTH(L), .INIT(INIT0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0.slave));
    srl_shift_responder #(.SRL_LENGTH(L), .INIT(INIT1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave));

    function automatic int fill();
        return (nshift < L) ? nshift : L;
    endfunction

    function automatic bit stage(int i, logic [L-1:0] init);
        int f = fill();
        if (i < f) return hist[i];
        return init[i - f];
    endfunction

    function automatic logic [15:0] exp_cnt();
        return (nshift > 65535) ? 16'hFFFF : 16'(nshift);
    endfunction

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: advance the model with the inputs seen at this edge.
    task automatic step();
        bit inject, b;
        @(posedge clk);
        if (rst) begin
            hist.delete();
            nshift = 0; pend = 0; ack_e = 0; qreg0 = 0; qreg1 = 0;
            chk_en = 1'b1;
        end else begin
            if (sh) begin
                inject = pend | req;
                b = d_i ^ inject;
                hist.push_front(b);
                if (hist.size() > 64) void'(hist.pop_back());
                nshift++;
                ack_e = inject;
                pend = 0;
            end else begin
                ack_e = 0;
                if (req) pend = 1;
            end
            qreg0 = stage(int'(a_i), INIT0);
            qreg1 = stage(int'(a_i), INIT1);
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1; sh = 0; req = 0; step(); rst = 0;
    endtask

    task automatic shift(bit b);
        sh = 1; d_i = b; step(); sh = 0;
    endtask

    task automatic peek(int x);
        sh = 0; a_i = 5'(x); step();
    endtask

    // Per-cycle comparison against the model, away from the clock edge.
    always @(negedge clk) begin
        if (chk_en) begin
`ifdef SRL_SHIFT_RESPONDER_QREG_EN
            check("m_srl_q0", {15'd0, bus0.srl_q}, {15'd0, qreg0});
            check("m_srl_q1", {15'd0, bus1.srl_q}, {15'd0, qreg1});
`else
            check("m_srl_q0", {15'd0, bus0.srl_q}, {15'd0, stage(int'(a_i), INIT0)});
            check("m_srl_q1", {15'd0, bus1.srl_q}, {15'd0, stage(int'(a_i), INIT1)});
`endif
            check("m_casc0", {15'd0, bus0.q_casc}, {15'd0, stage(L-1, INIT0)});
            check("m_casc1", {15'd0, bus1.q_casc}, {15'd0, stage(L-1, INIT1)});
            check("m_tv0", {15'd0, bus0.tap_valid}, {15'd0, fill() > int'(a_i)});
            check("m_tv1", {15'd0, bus1.tap_valid}, {15'd0, fill() > int'(a_i)});
            check("m_ack0", {15'd0, bus0.inj_ack}, {15'd0, ack_e});
            check("m_ack1", {15'd0, bus1.inj_ack}, {15'd0, ack_e});
            check("m_cnt0", bus0.shift_cnt, exp_cnt());
            check("m_cnt1", bus1.shift_cnt, exp_cnt());
        end
    end

    initial begin
        do_reset();

        // Nonzero INIT visible after reset, then one shift of 0
        peek(0);
        check("init_q_a0", {15'd0, bus1.srl_q}, 16'd1);
        check("init_casc", {15'd0, bus1.q_casc}, 16'd1);
        check("init_tv", {15'd0, bus1.tap_valid}, 16'd0);
        shift(0);
        peek(1);
        check("init_q_a1", {15'd0, bus1.srl_q}, 16'd1);
        check("init_casc_sh", {15'd0, bus1.q_casc}, 16'd0);

        // Shift in 1,0,1,1 into the zero-INIT instance
        do_reset();
        shift(1); shift(0); shift(1); shift(1);
        peek(0); check("tap_a0", {15'd0, bus0.srl_q}, 16'd1);
        peek(3); check("tap_a3", {15'd0, bus0.srl_q}, 16'd1);
        peek(2); check("tap_a2", {15'd0, bus0.srl_q}, 16'd0);
        peek(4); check("tv_a4", {15'd0, bus0.tap_valid}, 16'd0);

        // Injection: request while idle, consumed by the next shift
        do_reset();
        req = 1; step(); req = 1; step(); req = 0;
        shift(0);
        check("inj_ack_hi", {15'd0, bus0.inj_ack}, 16'd1);
        shift(0);
        check("inj_ack_lo", {15'd0, bus0.inj_ack}, 16'd0);
        peek(1); check("inj_bit", {15'd0, bus0.srl_q}, 16'd1);
        peek(0); check("inj_clean", {15'd0, bus0.srl_q}, 16'd0);

        // Reset wins over shift and injection on the same edge
        do_reset();
        for (int i = 0; i < 7; i++) shift(1);
        check("cnt7", bus0.shift_cnt, 16'd7);
        rst = 1; sh = 1; req = 1; step(); rst = 0; sh = 0; req = 0;
        check("rst_cnt", bus0.shift_cnt, 16'd0);
        check("rst_ack", {15'd0, bus0.inj_ack}, 16'd0);
        check("rst_casc", {15'd0, bus1.q_casc}, 16'd1);
        peek(0); check("rst_q1", {15'd0, bus1.srl_q}, 16'd1);
        check("rst_ack2", {15'd0, bus0.inj_ack}, 16'd0);

        // 40 shifts of 1010...: fill saturates, all taps valid
        do_reset();
        for (int i = 0; i < 40; i++) shift((i % 2) == 0);
        check("cnt40", bus0.shift_cnt, 16'd40);
        peek(31); check("tv_a31", {15'd0, bus0.tap_valid}, 16'd1);
        peek(0);  check("tv_a0", {15'd0, bus0.tap_valid}, 16'd1);
        check("alt_a0", {15'd0, bus0.srl_q}, 16'd0);
        peek(1);  check("alt_a1", {15'd0, bus0.srl_q}, 16'd1);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            sh  = ($urandom_range(0, 2) != 0);
            d_i = 1'($urandom);
            req = ($urandom_range(0, 7) == 0);
            a_i = 5'($urandom);
            step();
        end
        rst = 0; sh = 0; req = 0;

        // Shift counter saturation
        do_reset();
        sh = 1;
        for (int i = 0; i < 65540; i++) begin
            d_i = 1'($urandom);
            if ((i % 97) == 0) a_i = 5'($urandom);
            step();
        end
        sh = 0;
        check("cnt_sat", bus0.shift_cnt, 16'hFFFF);
        step();
        check("cnt_hold", bus0.shift_cnt, 16'hFFFF);

        @(posedge clk); #1;
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
